// File: rtl/sw_pkg.sv
// sw_pkg: shared state encoding and parameter helpers for the stopwatch control stage.
package sw_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} swState_t;

    function automatic int tickDiv(input int clkHz, input int tickHz);
        return clkHz / tickHz;
    endfunction

    function automatic int debCnt(input int clkHz, input int debMs);
        return (clkHz / 1000) * debMs;
    endfunction

    function automatic int widthOf(input int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: 2-FF synchronizer, DEB_CNT-cycle debouncer and rising-edge event for one raw input.
module sw_debounce import sw_pkg::*; #(
    parameter int DEB_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise
);
    localparam int CW = widthOf(DEB_CNT);

    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic diff, done;

    assign diff = sync[1] ^ dout;
    assign done = diff && cnt == CW'(DEB_CNT - 1);

    // Any cycle where the synchronized value matches dout restarts the window
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sync <= '0;
            cnt  <= '0;
            dout <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            cnt  <= (diff && !done) ? cnt + 1'b1 : '0;
            dout <= done ? sync[1] : dout;
            rise <= done && sync[1];
        end
endmodule

// File: rtl/sw_control.sv
// sw_control: debounced start/clear/direction inputs, IDLE/RUN/PAUSE FSM and count-tick prescaler.
// Optional lap-hold feature under macro SW_LAP_EN.
module sw_control import sw_pkg::*; #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 10,
    parameter int DEB_MS  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_start,
    input  logic btn_clr,
    input  logic sw_dir,
`ifdef SW_LAP_EN
    input  logic btn_lap,
    output logic lap_hold,
`endif
    output logic enable,
    output logic clockEnable,
    output logic upDown,
    output logic clr,
    output logic running
);
    localparam int TICK_DIV = tickDiv(CLK_HZ, TICK_HZ);
    localparam int DEB_CNT  = debCnt(CLK_HZ, DEB_MS);
    localparam int PW       = widthOf(TICK_DIV);

    logic startEv, clrEv, dirLvl, wrap;
    logic unusedStartLvl, unusedClrLvl, unusedDirRise;
    logic [PW-1:0] presc;
    swState_t state, nextState;

    sw_debounce #(.DEB_CNT(DEB_CNT)) uStart (.clk(clk), .rst(rst), .din(btn_start), .dout(unusedStartLvl), .rise(startEv));
    sw_debounce #(.DEB_CNT(DEB_CNT)) uClr   (.clk(clk), .rst(rst), .din(btn_clr),   .dout(unusedClrLvl),   .rise(clrEv));
    sw_debounce #(.DEB_CNT(DEB_CNT)) uDir   (.clk(clk), .rst(rst), .din(sw_dir),    .dout(dirLvl),         .rise(unusedDirRise));

    // Clear dominates a simultaneous start event
    assign nextState = clrEv    ? IDLE
                     : !startEv ? state
                     : state == RUN ? PAUSE : RUN;
    assign wrap = presc == PW'(TICK_DIV - 1);

    // Outputs are registered from nextState so they line up with the state register
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            enable      <= 1'b0;
            running     <= 1'b0;
            clockEnable <= 1'b0;
            clr         <= 1'b0;
            upDown      <= 1'b0;
        end else begin
            state       <= nextState;
            enable      <= nextState == RUN;
            running     <= nextState == RUN;
            clockEnable <= nextState == RUN && wrap;
            clr         <= clrEv;
            presc       <= nextState == IDLE ? '0
                         : nextState == RUN  ? (wrap ? '0 : presc + 1'b1)
                         : presc;
            upDown      <= nextState == RUN ? upDown : dirLvl;
        end

`ifdef SW_LAP_EN
    logic lapEv, unusedLapLvl;

    sw_debounce #(.DEB_CNT(DEB_CNT)) uLap (.clk(clk), .rst(rst), .din(btn_lap), .dout(unusedLapLvl), .rise(lapEv));

    always_ff @(posedge clk or negedge rst)
        if (!rst)
            lap_hold <= 1'b0;
        else
            lap_hold <= nextState == IDLE ? 1'b0
                      : (state == RUN && lapEv) ? ~lap_hold
                      : lap_hold;
`endif
endmodule

// File: tb/tb_sw_control.sv
// tb_sw_control: directed stimulus with a tick/clear event scoreboard for sw_control.
module tb_sw_control;
    logic clk = 1'b0, rst = 1'b1, btn_start = 1'b0, btn_clr = 1'b0, sw_dir = 1'b0;
    logic enable, clockEnable, upDown, clr, running;
`ifdef SW_LAP_EN
    logic btn_lap = 1'b0, lap_hold;
`endif
    int cyc = 0, checks = 0, errors = 0;
    int p, t0, q, z, w, s, u;

    typedef struct {bit isClr; int at;} ev_t;
    ev_t expQ[$];

    sw_control #(.CLK_HZ(1000), .TICK_HZ(100), .DEB_MS(4)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clr(btn_clr), .sw_dir(sw_dir),
`ifdef SW_LAP_EN
        .btn_lap(btn_lap), .lap_hold(lap_hold),
`endif
        .enable(enable), .clockEnable(clockEnable), .upDown(upDown), .clr(clr), .running(running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every tick or clear pulse must match the next expected event exactly
    always @(negedge clk)
        if (clockEnable || clr) begin
            ev_t e;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL unexpected_%s at cycle %0d: no event expected", clr ? "clr" : "tick", cyc);
            end else begin
                e = expQ.pop_front();
                if (e.isClr != clr || e.at != cyc || (clr ? clockEnable : !enable)) begin
                    errors++;
                    $display("FAIL event got %s at cycle %0d (enable=%0b) expected %s at cycle %0d",
                             clr ? "clr" : "tick", cyc, enable, e.isClr ? "clr" : "tick", e.at);
                end
            end
        end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic upTo(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic pushTicks(input int first, input int last);
        for (int t = first; t <= last; t += 10) expQ.push_back('{1'b0, t});
    endtask

    task automatic pushClr(input int at);
        expQ.push_back('{1'b1, at});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        step(3);
        chk("reset_outs", 8'({enable, clockEnable, upDown, clr, running}), 8'h00);
        rst = 1'b1;
        sw_dir = 1'b1;
        step(1);
        chk("idle_outs", 8'({enable, clockEnable, upDown, clr, running}), 8'h00);
        step(10);
        chk("updown_follow_idle", 8'(upDown), 8'h01);

        // short bounces never reach the debounce window
        repeat (5) begin
            btn_start = 1'b1; step(3);
            btn_start = 1'b0; step(3);
        end
        step(10);
        chk("bounce_stays_idle", 8'(running), 8'h00);

        p = cyc;
        btn_start = 1'b1;
        pushTicks(p + 16, p + 36);
        upTo(p + 6);  chk("start_not_yet", 8'(running), 8'h00);
        upTo(p + 7);  chk("start_run_at_7", 8'({enable, running}), 8'h03);
        upTo(p + 12); btn_start = 1'b0;

        t0 = p + 36;
        upTo(t0 + 1); btn_start = 1'b1;
        upTo(t0 + 7); chk("still_run", 8'(running), 8'h01);
        upTo(t0 + 8); chk("paused", 8'({enable, running}), 8'h00);
        upTo(t0 + 9); btn_start = 1'b0;

        q = t0 + 58;
        upTo(q); btn_start = 1'b1;
        pushTicks(q + 9, q + 29);
        upTo(q + 6);  chk("pause_held", 8'(running), 8'h00);
        upTo(q + 7);  chk("resumed", 8'(running), 8'h01);
        upTo(q + 8);  btn_start = 1'b0;
        upTo(q + 10); sw_dir = 1'b0;
        upTo(q + 30); chk("updown_frozen_run", 8'(upDown), 8'h01);

        z = q + 31;
        upTo(z); btn_start = 1'b1;
        upTo(z + 6); chk("updown_before_pause", 8'(upDown), 8'h01);
        upTo(z + 7); chk("updown_after_pause", 8'({upDown, running}), 8'h00);
        upTo(z + 8); btn_start = 1'b0;

        w = z + 20;
        upTo(w); btn_start = 1'b1;
        pushTicks(w + 8, w + 18);
        upTo(w + 7); chk("resume2", 8'(running), 8'h01);
        upTo(w + 8); btn_start = 1'b0;

        s = w + 16;
        upTo(s); btn_start = 1'b1; btn_clr = 1'b1;
        pushClr(s + 7);
        upTo(s + 6); chk("pre_clr_run", 8'(running), 8'h01);
        upTo(s + 7); chk("clr_wins_idle", 8'({enable, running}), 8'h00);
        upTo(s + 8); btn_start = 1'b0; btn_clr = 1'b0;

        u = s + 20;
        upTo(u); btn_start = 1'b1;
        pushTicks(u + 16, u + 16);
        upTo(u + 7);  chk("run_after_clr", 8'(running), 8'h01);
        upTo(u + 8);  btn_start = 1'b0;
        upTo(u + 20); rst = 1'b0;
        #1;
        chk("async_reset_drop", 8'({enable, clockEnable, clr, running}), 8'h00);
        step(2);
        rst = 1'b1;
        step(3);
        chk("idle_after_reset", 8'({enable, running}), 8'h00);

`ifdef SW_LAP_EN
        p = cyc + 1;
        upTo(p); btn_start = 1'b1;
        pushTicks(p + 16, p + 26);
        pushClr(p + 27);
        upTo(p + 8);  btn_start = 1'b0;
        upTo(p + 10); btn_lap = 1'b1;
        upTo(p + 16); chk("lap_not_yet", 8'(lap_hold), 8'h00);
        upTo(p + 17); chk("lap_hold_set", 8'({lap_hold, running}), 8'h03);
        upTo(p + 18); btn_lap = 1'b0;
        upTo(p + 20); btn_clr = 1'b1;
        upTo(p + 27); chk("lap_cleared", 8'({lap_hold, running}), 8'h00);
        upTo(p + 28); btn_clr = 1'b0;
`endif

        step(20);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left expected 0 (next at cycle %0d)", expQ.size(), expQ[0].at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
